// File: rtl/network_run_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : network_run_driver_if
// Description : Request, controller and result signals of the network run
//               driver, bundled into one interface. The host/controller side
//               uses the master modport and the driver uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface network_run_driver_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7
);
  logic              req_valid;
  logic              req_ready;
  logic [HEIGHT-1:0] req_pixels;
  logic [HEIGHT-1:0] net_pixels;
  logic              net_start;
  logic [1:0]        net_out;
  logic              res_valid;
  logic              res_ready;
  logic              res_spike;
  logic [WIDTH+1:0]  res_latency;
  logic              res_timeout;
  logic [WIDTH+1:0]  spike_count;

  modport master (
    output req_valid, req_pixels, net_out, res_ready,
    input  req_ready, net_pixels, net_start, res_valid, res_spike,
           res_latency, res_timeout, spike_count
  );

  modport slave (
    input  req_valid, req_pixels, net_out, res_ready,
    output req_ready, net_pixels, net_start, res_valid, res_spike,
           res_latency, res_timeout, spike_count
  );
endinterface
`default_nettype wire

// File: rtl/network_run_driver.sv
`default_nettype none
// ============================================================================
// Module      : network_run_driver
// Description : Host-side initiator for the network run controller. Accepts a
//               pixel column, pulses start, watches the 2-bit controller
//               result and returns spike flag, first-spike latency and
//               timeout status over a valid/ready handshake.
//               Optional macro NETWORK_RUN_DRIVER_SPIKE_COUNT_EN enables the
//               spike rising-edge counter; otherwise spike_count reads 0.
//               GUARD must be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
module network_run_driver #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7,
  parameter int GUARD  = 2,
  parameter int SLACK  = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  network_run_driver_if.slave  bus
);
  localparam int c_TIMEOUT_INT = (1 << (WIDTH + 1)) + GUARD + SLACK - 1;
  localparam int c_GUARD_INT   = GUARD;
  localparam logic [WIDTH+1:0] c_TIMEOUT_CYC = c_TIMEOUT_INT[WIDTH+1:0];
  localparam logic [WIDTH+1:0] c_GUARD_CYC   = c_GUARD_INT[WIDTH+1:0];

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_START = 3'd1;
  localparam logic [2:0] c_ST_GUARD = 3'd2;
  localparam logic [2:0] c_ST_RUN   = 3'd3;
  localparam logic [2:0] c_ST_HOLD  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [WIDTH+1:0]  r_cyc;
  logic [HEIGHT-1:0] r_net_pixels;
  logic              r_net_start;
  logic              r_res_valid;
  logic              r_res_spike;
  logic [WIDTH+1:0]  r_res_latency;
  logic              r_res_timeout;

  logic w_req_ready;
  logic w_accept;
  logic w_observe;
  logic w_spike_now;
  logic w_done;
  logic w_limit;
  logic w_run_end;
  logic w_res_take;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: IDLE -> START -> GUARD -> RUN -> HOLD -> IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_accept) w_state_next = c_ST_START;
      c_ST_START: w_state_next = c_ST_GUARD;
      c_ST_GUARD: if (r_cyc == c_GUARD_CYC) w_state_next = c_ST_RUN;
      c_ST_RUN:   if (w_run_end) w_state_next = c_ST_HOLD;
      c_ST_HOLD:  if (w_res_take) w_state_next = c_ST_IDLE;
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  // Decode: handshakes, spike observation window, run termination
  always_comb begin
    w_req_ready = (r_state == c_ST_IDLE) && !rst;
    w_accept    = w_req_ready && bus.req_valid;
    w_observe   = (r_state == c_ST_GUARD) || (r_state == c_ST_RUN);
    w_spike_now = w_observe && bus.net_out[0];
    // done flag is meaningless during GUARD (reads 1 while controller idles)
    w_done      = (r_state == c_ST_RUN) && bus.net_out[1];
    w_limit     = (r_state == c_ST_RUN) && (r_cyc == c_TIMEOUT_CYC);
    w_run_end   = w_done || w_limit;
    w_res_take  = (r_state == c_ST_HOLD) && bus.res_ready;
  end

  // Datapath: pixel latch, start pulse, run counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_net_pixels  <= '0;
      r_net_start   <= 1'b0;
      r_cyc         <= '0;
      r_res_valid   <= 1'b0;
      r_res_spike   <= 1'b0;
      r_res_latency <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_net_start <= w_accept;
      if (w_accept) begin
        r_net_pixels  <= bus.req_pixels;
        r_cyc         <= '0;
        r_res_valid   <= 1'b0;
        r_res_spike   <= 1'b0;
        r_res_latency <= '0;
        r_res_timeout <= 1'b0;
      end else if ((r_state != c_ST_IDLE) && (r_state != c_ST_HOLD) && (r_cyc != '1)) begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (w_spike_now && !r_res_spike) begin
        r_res_spike   <= 1'b1;
        r_res_latency <= r_cyc;
      end
      if (w_run_end) begin
        r_res_valid   <= 1'b1;
        // a spike in the final cycle still counts as a spike
        r_res_timeout <= !w_done && !(r_res_spike || bus.net_out[0]);
        if (!r_res_spike && !bus.net_out[0]) r_res_latency <= '1;
      end
      if (w_res_take) r_res_valid <= 1'b0;
    end
  end

`ifdef NETWORK_RUN_DRIVER_SPIKE_COUNT_EN
  logic             r_prev_spike;
  logic [WIDTH+1:0] r_spike_count;

  // Count 0->1 edges of the spike line; previous sample is forced low at START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_spike  <= 1'b0;
      r_spike_count <= '0;
    end else begin
      if (w_accept) r_spike_count <= '0;
      if (r_state == c_ST_START) begin
        r_prev_spike <= 1'b0;
      end else if (w_observe) begin
        r_prev_spike <= bus.net_out[0];
        if (bus.net_out[0] && !r_prev_spike && (r_spike_count != '1))
          r_spike_count <= r_spike_count + 1'b1;
      end
    end
  end

  assign bus.spike_count = r_spike_count;
`else
  assign bus.spike_count = '0;
`endif

  assign bus.req_ready   = w_req_ready;
  assign bus.net_pixels  = r_net_pixels;
  assign bus.net_start   = r_net_start;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_spike   = r_res_spike;
  assign bus.res_latency = r_res_latency;
  assign bus.res_timeout = r_res_timeout;

endmodule
`default_nettype wire

// File: tb/tb_network_run_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_network_run_driver
// Description : Directed self-checking bench for network_run_driver with a
//               scripted network run controller model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_network_run_driver;
  localparam int c_WIDTH  = 8;
  localparam int c_HEIGHT = 7;
  localparam int c_ALL1   = 1023;
`ifdef NETWORK_RUN_DRIVER_SPIKE_COUNT_EN
  localparam int c_SC_ONE   = 1;
  localparam int c_SC_THREE = 3;
`else
  localparam int c_SC_ONE   = 0;
  localparam int c_SC_THREE = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   end_k;

  network_run_driver_if #(.WIDTH(c_WIDTH), .HEIGHT(c_HEIGHT)) bus ();

  network_run_driver #(.WIDTH(c_WIDTH), .HEIGHT(c_HEIGHT), .GUARD(2), .SLACK(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller result for cycle k after the start pulse (k=0 is START)
  function automatic logic [1:0] model_out(input int mode, input int k);
    logic [1:0] v;
    v = 2'b00;
    case (mode)
      0: v = (k >= 40) ? 2'b01 : 2'b00;
      1: v = (k <= 2 || k >= 511) ? 2'b10 : 2'b00;
      2: v = 2'b00;
      3: v = (k == 10 || k == 20 || k == 30) ? 2'b01 : ((k >= 35) ? 2'b10 : 2'b00);
      4: v = (k >= 50) ? 2'b01 : 2'b00;
      5: v = 2'b10;
      6: v = (k == 529) ? 2'b10 : 2'b00;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  // Issue a request at the current negedge, then play the controller model.
  // end_k: cycle index where res_valid first appears, -2 if aborted, 700 if never.
  task automatic do_run(input int mode, input logic [6:0] px, input int abort_k, output int ek);
    bit stop;
    ek = 700;
    stop = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_pixels = px;
    check_eq("req_ready_at_req", bus.req_ready, 1);
    check_eq("start_low_before", bus.net_start, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("start_pulse", bus.net_start, 1);
    check_eq("net_pixels", bus.net_pixels, px);
    bus.net_out = model_out(mode, 0);
    for (int k = 1; k < 700 && !stop; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("start_one_cycle", bus.net_start, 0);
      if (bus.res_valid) begin
        ek = k;
        bus.net_out = 2'b00;
        stop = 1'b1;
      end else if (k == abort_k) begin
        bus.net_out = 2'b00;
        rst = 1'b1;
        ek = -2;
        stop = 1'b1;
      end else begin
        bus.net_out = model_out(mode, k);
      end
    end
  endtask

  // Take the result and confirm the return to IDLE
  task automatic take_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_eq("valid_drop", bus.res_valid, 0);
    check_eq("ready_after", bus.req_ready, 1);
  endtask

  task automatic check_res(input string tag, input int ek, input int exp_k, input int sp,
                           input int lat, input int to, input int sc);
    check_eq({tag, "_end"}, ek, exp_k);
    check_eq({tag, "_spike"}, bus.res_spike, sp);
    check_eq({tag, "_latency"}, bus.res_latency, lat);
    check_eq({tag, "_timeout"}, bus.res_timeout, to);
    check_eq({tag, "_count"}, bus.spike_count, sc);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_pixels = '0;
    bus.net_out = 2'b00;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_net_start", bus.net_start, 0);
    check_eq("rst_net_pixels", bus.net_pixels, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_latency", bus.res_latency, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", bus.req_ready, 1);

    // Spike held from cyc 40, no done flag: ends by count at cyc 529
    do_run(0, 7'h7F, -1, end_k);
    check_res("spike_to", end_k, 530, 1, 40, 0, c_SC_ONE);
    check_eq("hold_pixels", bus.net_pixels, 7'h7F);
    take_result();

    // Done flag during GUARD is ignored; real done at cyc 511
    do_run(1, 7'h01, -1, end_k);
    check_res("guard_ign", end_k, 512, 0, c_ALL1, 0, 0);
    take_result();

    // Silent controller: timeout, result held while consumer stalls
    do_run(2, 7'h33, -1, end_k);
    check_res("timeout", end_k, 530, 0, c_ALL1, 1, 0);
    bus.req_valid  = 1'b1;
    bus.req_pixels = 7'h2A;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_timeout !== 1'b1 || bus.res_latency !== 10'h3FF ||
          bus.req_ready !== 1'b0 || bus.net_pixels !== 7'h33 || bus.net_start !== 1'b0) bad++;
    end
    check_eq("hold_stable", bad, 0);
    bus.req_valid = 1'b0;
    take_result();

    // Minimum latency: done asserted from the first RUN cycle
    do_run(5, 7'h0F, -1, end_k);
    check_res("min_lat", end_k, 4, 0, c_ALL1, 0, 0);
    take_result();

    // Done and count limit in the same cycle: done wins
    do_run(6, 7'h40, -1, end_k);
    check_res("both", end_k, 530, 0, c_ALL1, 0, 0);
    take_result();

    // Reset mid-run after a spike was captured
    do_run(4, 7'h55, 100, end_k);
    check_eq("abort_k", end_k, -2);
    #1;
    check_eq("mid_rst_ready", bus.req_ready, 0);
    check_eq("mid_rst_pixels", bus.net_pixels, 0);
    check_eq("mid_rst_spike", bus.res_spike, 0);
    check_eq("mid_rst_latency", bus.res_latency, 0);
    check_eq("mid_rst_count", bus.spike_count, 0);
    check_eq("mid_rst_valid", bus.res_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
    end
    check_eq("no_partial", bad, 0);

    // Fresh run after reset: three single-cycle spikes then done
    do_run(3, 7'h15, -1, end_k);
    check_res("three", end_k, 36, 1, 10, 0, c_SC_THREE);
    check_eq("three_pixels", bus.net_pixels, 7'h15);
    take_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
